// File: rtl/wb_result_arbiter.sv
// Writeback arbiter: merges one unstallable pipeline result stream with held
// multi-cycle unit results, with branch squash and starvation bubble requests.
package wb_pkg;
  localparam int SQN_W = 7;

  typedef struct packed {
    logic             taken;
    logic [SQN_W-1:0] sqN;
  } BranchProv;

  typedef struct packed {
    logic             valid;
    logic [SQN_W-1:0] sqN;
    logic [4:0]       tagDst;
    logic [31:0]      result;
  } RES_UOp;

  // Younger than the branch (positive wrapped distance) means squashed.
  function automatic logic killed(BranchProv b, logic [SQN_W-1:0] sq);
    logic [SQN_W-1:0] d;
    d = sq - b.sqN;
    return b.taken && !d[SQN_W-1] && (d != '0);
  endfunction
endpackage

module wb_mc_lane
  import wb_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  BranchProv branch,
  input  RES_UOp    uop,
  input  logic      grant,
  output logic      live,
  output logic      starved
);
  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [3:0] wait_cnt, wait_nxt;

  assign live = uop.valid && !killed(branch, uop.sqN);

  always_comb begin
    wait_nxt = '0;
    if (live && !grant) wait_nxt = (wait_cnt == LIM) ? LIM : wait_cnt + 4'd1;
  end

  assign starved = (wait_nxt == LIM);

  always_ff @(posedge clk) begin
    if (!rst) wait_cnt <= '0;
    else      wait_cnt <= wait_nxt;
  end
endmodule

module wb_result_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_MC     = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  BranchProv         IN_branch,
  input  RES_UOp            IN_pipeUop,
  input  RES_UOp            IN_mcUops [NUM_MC],
  output logic [NUM_MC-1:0] OUT_wbAvail,
  output logic              OUT_stallPipe,
  output RES_UOp            OUT_uop
);
  localparam int PTR_W = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;

  logic [PTR_W-1:0]  rr_ptr, g_idx, rr_nxt;
  logic [NUM_MC-1:0] mc_live, starved, grant;
  logic              pipe_live, found;
  int                idx;

  assign pipe_live = IN_pipeUop.valid && !killed(IN_branch, IN_pipeUop.sqN);

  always_comb begin
    grant = '0;
    g_idx = '0;
    found = 1'b0;
    idx   = 0;
    if (!pipe_live) begin
      for (int k = 0; k < NUM_MC; k++) begin
        idx = (int'(rr_ptr) + k) % NUM_MC;
        if (!found && mc_live[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          g_idx      = PTR_W'(idx);
        end
      end
    end
    rr_nxt = (int'(g_idx) == NUM_MC - 1) ? '0 : g_idx + PTR_W'(1);
  end

  // Held during reset so no source retires a result that nobody captured.
  assign OUT_wbAvail = rst ? grant : '0;

  for (genvar i = 0; i < NUM_MC; i++) begin : g_lane
    wb_mc_lane #(.STARVE_LIM(STARVE_LIM)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .branch  (IN_branch),
      .uop     (IN_mcUops[i]),
      .grant   (OUT_wbAvail[i]),
      .live    (mc_live[i]),
      .starved (starved[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      OUT_uop       <= '0;
      OUT_stallPipe <= 1'b0;
      rr_ptr        <= '0;
    end else begin
      OUT_stallPipe <= |starved;
      if (pipe_live) begin
        OUT_uop <= IN_pipeUop;
      end else if (found) begin
        OUT_uop <= IN_mcUops[g_idx];
        rr_ptr  <= rr_nxt;
      end else begin
        OUT_uop.valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/wb_result_arbiter.md
Name: wb_result_arbiter

Overview:
- Writeback-side consumer for multi-cycle execution units (FP divide/sqrt, integer divide) that present a held RES_UOp and clear it on IN_wbAvail.
- Merges these results with one fixed-latency pipeline result stream into a single registered writeback port.
- Issues per-source wbAvail grants, drops results squashed by a taken branch, and requests a pipeline bubble when a multi-cycle source starves.

Parameters:
- NUM_MC, 2, number of multi-cycle result sources.
- STARVE_LIM, 4, wait cycles before a bubble is requested; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- IN_branch  in  BranchProv  branch/flush info; uses .taken and .sqN.
- IN_pipeUop  in  RES_UOp  fixed-latency pipeline result; cannot be stalled.
- IN_mcUops  in  RES_UOp[NUM_MC]  multi-cycle unit results; each is held valid until granted.
- OUT_wbAvail  out  NUM_MC  combinational grant; the source clears its valid at the next edge.
- OUT_stallPipe  out  1  registered request to the issue stage to leave a pipeline slot empty.
- OUT_uop  out  RES_UOp  registered writeback result.

Behaviour:
- Kill test: killed(u) = IN_branch.taken && $signed(u.sqN - IN_branch.sqN) > 0, using sqN subtraction at native width.
- Live(u) = u.valid && !killed(u).
- Selection per cycle:
  - If Live(IN_pipeUop): OUT_uop <= IN_pipeUop at the next edge; OUT_wbAvail = 0.
  - Otherwise, scan i = rrPtr, rrPtr+1, ... modulo NUM_MC and pick the first Live(IN_mcUops[i]) as g. Then OUT_wbAvail[g] = 1 in the same cycle, OUT_uop <= IN_mcUops[g], rrPtr <= (g+1) mod NUM_MC.
  - Otherwise: OUT_uop.valid <= 0; rrPtr unchanged.
- Latency: one cycle from selection to OUT_uop.valid. OUT_uop is valid for exactly one cycle per result; there is no hold and no downstream backpressure.
- A killed pipeline uop frees the slot in that same cycle, so a live multi-cycle source may be granted.
- Killed multi-cycle uops are never granted. The source self-clears them on the branch.
- At most one OUT_wbAvail bit is high in any cycle.
- Starvation counters, one waitCnt[i] per source, 4 bits:
  - Increment, saturating at STARVE_LIM, when Live(IN_mcUops[i]) and i is not granted.
  - Clear when i is granted or the source is not Live.
- OUT_stallPipe <= OR over i of (waitCnt_next[i] == STARVE_LIM).
- Live pipeline results still win while OUT_stallPipe is high. The bubble is advisory and correctness does not depend on it.
- Reset (rst == 0 at a clock edge):
  - OUT_uop.valid = 0, OUT_stallPipe = 0, rrPtr = 0, all waitCnt = 0.
  - OUT_wbAvail is forced to 0 combinationally while rst == 0, so no source drops a result during reset.
- Reset mid-operation discards any in-flight OUT_uop. Held multi-cycle results are re-arbitrated after reset deasserts.
- OUT_uop fields other than valid are don't-care when valid = 0.

Test Plan:
- Only IN_mcUops[0] valid (sqN=3, result=32'h3F800000), pipeline idle -> OUT_wbAvail=2'b01 in the same cycle; next cycle OUT_uop.valid=1 with result 32'h3F800000 and sqN=3.
- Both sources valid, rrPtr=0, pipeline idle -> grants 2'b01 then 2'b10 on consecutive cycles; rrPtr returns to 0.
- IN_pipeUop valid every cycle, source 0 valid -> no grant; OUT_stallPipe=1 from the 4th wait cycle onward. On the first pipeline gap source 0 is granted, and OUT_stallPipe=0 the following cycle.
- Branch taken, sqN=10; source 0 sqN=12, source 1 sqN=8, rrPtr=0 -> only OUT_wbAvail[1]=1; next cycle OUT_uop.sqN=8.
- Pipeline uop sqN=15 killed by branch sqN=10 while source 0 is valid with sqN=5 -> source 0 granted in the same cycle; next cycle OUT_uop.sqN=5.
- rst=0 for 2 cycles while source 0 is valid and waitCnt=3 -> OUT_wbAvail=0 during reset; after reset OUT_uop.valid=0, OUT_stallPipe=0, waitCnt=0, then source 0 is granted on the first cycle after rst=1.
